// File: rtl/block_scroller.sv
// Obstacle-column scroller: buffers incoming columns in a 2-entry FIFO, shifts them
// across the playfield once per tick, detects player collisions and keeps the score.
module block_scroller #(
    parameter int unsigned COLS     = 16,
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 blk_valid,
    input  logic [7:0]           blk_data,
    output logic                 blk_ready,
    input  logic [7:0]           player_mask,
    output logic [COLS*8-1:0]    field,
    output logic                 running,
    output logic                 hit,
    output logic [15:0]          score
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [COLS-1:0][7:0]   field_q, field_d;
    logic [1:0][7:0]        buf_q, buf_d;
    logic [1:0]             count_q, count_d;
    logic [CNT_W-1:0]       tick_q, tick_d;
    logic [15:0]            score_q, score_d;

    logic                   collide;
    logic                   step;
    logic                   push;
    logic                   pop;
    logic [1:0]             count_mid;
    logic [7:0]             head;

    // Ready depends only on registered state so the producer never sees a combinational loop.
    assign blk_ready = (state_q == ST_RUN) && (count_q < 2'd2);
    assign running   = (state_q == ST_RUN);
    assign hit       = collide;
    assign field     = field_q;
    assign score     = score_q;

    always_comb begin
        state_d   = state_q;
        field_d   = field_q;
        buf_d     = buf_q;
        count_d   = count_q;
        tick_d    = tick_q;
        score_d   = score_q;
        collide   = 1'b0;
        step      = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        count_mid = count_q;
        head      = 8'h00;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_RUN;
                    field_d = '0;
                    buf_d   = '0;
                    count_d = 2'd0;
                    tick_d  = '0;
                    score_d = 16'h0000;
                end
            end
            ST_RUN: begin
                collide = |(field_q[0] & player_mask);
                if (collide) begin
                    // Freeze field and score for display; any coinciding step is dropped.
                    state_d = ST_OVER;
                end else begin
                    step   = (tick_q == TICK_LAST);
                    tick_d = step ? '0 : tick_q + CNT_W'(1);
                    push   = blk_valid && blk_ready;
                    if (step) begin
                        pop     = (count_q != 2'd0);
                        head    = pop ? buf_q[0] : 8'h00;
                        field_d = {head, field_q[COLS-1:1]};
                        if ((field_q[0] != 8'h00) && (score_q != 16'hFFFF)) begin
                            score_d = score_q + 16'd1;
                        end
                    end
                    if (pop) begin
                        buf_d[0] = buf_q[1];
                    end
                    count_mid = count_q - 2'(pop);
                    if (push) begin
                        if (count_mid == 2'd0) begin
                            buf_d[0] = blk_data;
                        end else begin
                            buf_d[1] = blk_data;
                        end
                    end
                    count_d = count_mid + 2'(push);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            field_q <= '0;
            buf_q   <= '0;
            count_q <= 2'd0;
            tick_q  <= '0;
            score_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            buf_q   <= buf_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            score_q <= score_d;
        end
    end

endmodule
